// File: rtl/resize_lerp_engine_pkg.sv
// Shared constants and fp16 arithmetic helpers for the resize lerp engine.
// Arithmetic truncates, and operands or results below the normal range become zero.
package resize_lerp_engine_pkg;

    localparam int ADDR_SZ = 16;
    localparam logic [15:0] FP16_ZERO  = 16'h0000;
    localparam logic [15:0] FP16_NZERO = 16'h8000;

    function automatic logic [15:0] fp16_add(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [15:0] x, y, r;
        logic [13:0] mx, my;
        logic [14:0] s;
        logic [4:0] d;
        logic signed [6:0] e;
        if (a[14:0] >= b[14:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        mx = {1'b1, x[9:0], 3'b000};
        my = (y[14:10] == 5'd0) ? 14'd0 : {1'b1, y[9:0], 3'b000};
        d  = x[14:10] - y[14:10];
        my = (d > 5'd13) ? 14'd0 : (my >> d);
        e  = $signed({2'b00, x[14:10]});
        if (x[15] == y[15]) begin
            s = {1'b0, mx} + {1'b0, my};
            if (s[14]) begin
                s = s >> 1;
                e = e + 7'sd1;
            end
        end else begin
            s = {1'b0, mx - my};
            for (int i = 0; i < 14; i++) begin
                if (!s[13] && s != 15'd0) begin
                    s = s << 1;
                    e = e - 7'sd1;
                end
            end
        end
        if (x[14:10] == 5'd0 || s == 15'd0 || e <= 7'sd0)
            r = FP16_ZERO;
        else if (x[14:10] == 5'h1f || e >= 7'sd31)
            r = {x[15], 5'h1f, 10'd0};
        else
            r = {x[15], e[4:0], s[12:3]};
        return r;
    endfunction

    function automatic logic [15:0] fp16_mul(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic sg;
        logic [21:0] p;
        logic [9:0] m;
        logic signed [6:0] e;
        logic [15:0] r;
        sg = a[15] ^ b[15];
        p  = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        e  = $signed({2'b00, a[14:10]}) + $signed({2'b00, b[14:10]}) - 7'sd15;
        if (p[21]) begin
            m = p[20:11];
            e = e + 7'sd1;
        end else begin
            m = p[19:10];
        end
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0 || e <= 7'sd0)
            r = {sg, 15'd0};
        else if (a[14:10] == 5'h1f || b[14:10] == 5'h1f || e >= 7'sd31)
            r = {sg, 5'h1f, 10'd0};
        else
            r = {sg, e[4:0], m};
        return r;
    endfunction

endpackage

// File: rtl/resize_lerp_engine_stage.sv
// fp16 primitives and the three-stage lerp pipeline: d=p2-p1, m=f*d, r=p1+m.
// The final add is combinational and gets registered by the engine's write path.
module sub_float
    import resize_lerp_engine_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    assign y = fp16_add(a, {~b[15], b[14:0]});
endmodule

module Multiply
    import resize_lerp_engine_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    assign y = fp16_mul(a, b);
endmodule

module fp16_lerp_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] p1,
    input  logic [15:0] p2,
    input  logic [15:0] f,
    output logic [15:0] result,
    output logic        result_valid
);
    logic [15:0] d, d_n, m, m_n, m_neg;
    logic        d_vld;

    sub_float u_sub (.a(p2), .b(p1), .y(d_n));
    Multiply  u_mul (.a(f), .b(d), .y(m_n));

    assign m_neg = {~m[15], m[14:0]};
    sub_float u_add (.a(p1), .b(m_neg), .y(result));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d            <= '0;
            m            <= '0;
            d_vld        <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            d_vld        <= start;
            result_valid <= d_vld;
            if (start) d <= d_n;
            if (d_vld) m <= m_n;
        end
    end
endmodule

// File: rtl/resize_lerp_engine.sv
// Resize lerp engine: fetches p1/p2 per job, blends them in fp16 and writes back.
// A zero fraction skips the p2 fetch so out-of-row neighbours are never read.
module resize_lerp_engine
    import resize_lerp_engine_pkg::*;
#(
    parameter int ADDR_W = ADDR_SZ,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] src_addr1,
    input  logic [ADDR_W-1:0] src_addr2,
    input  logic [ADDR_W-1:0] des_addr,
    input  logic [15:0]       fraction,
    input  logic              done_in,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              done_out
);
    typedef enum logic [2:0] {
        IDLE, RD1, RD2, WAIT, SUB, MUL, ADD
    } state_t;

    localparam logic [2:0] LAT1 = 3'(RD_LAT);
    localparam logic [2:0] LAT2 = 3'(RD_LAT + 1);

    state_t            state;
    logic [ADDR_W-1:0] addr1, addr2, addr_d;
    logic [15:0]       frac, p1, p2, lerp_res;
    logic [2:0]        cnt;
    logic              done_seen, skip, lerp_start, lerp_vld;

    assign skip       = (frac == FP16_ZERO) || (frac == FP16_NZERO);
    assign lerp_start = (state == SUB);

    fp16_lerp_stage u_lerp (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (lerp_start),
        .p1           (p1),
        .p2           (p2),
        .f            (frac),
        .result       (lerp_res),
        .result_valid (lerp_vld)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            done_out    <= 1'b0;
            done_seen   <= 1'b0;
            addr1       <= '0;
            addr2       <= '0;
            addr_d      <= '0;
            frac        <= '0;
            p1          <= '0;
            p2          <= '0;
            cnt         <= '0;
        end else begin
            mem_wr_en <= 1'b0;
            done_seen <= done_seen | done_in;
            // cnt counts cycles since the p1 strobe
            if ((state == RD2 || state == WAIT) && cnt == LAT1)
                p1 <= mem_rd_data;
            if (state == WAIT && cnt == LAT2)
                p2 <= mem_rd_data;
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        addr1       <= src_addr1;
                        addr2       <= src_addr2;
                        addr_d      <= des_addr;
                        frac        <= fraction;
                        in_ready    <= 1'b0;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= src_addr1;
                        cnt         <= '0;
                        state       <= RD1;
                    end else if (done_seen || done_in) begin
                        done_out <= 1'b1;
                        in_ready <= 1'b0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                RD1: begin
                    cnt <= cnt + 3'd1;
                    if (skip) begin
                        mem_rd_en <= 1'b0;
                        state     <= WAIT;
                    end else begin
                        mem_rd_addr <= addr2;
                        state       <= RD2;
                    end
                end
                RD2: begin
                    cnt       <= cnt + 3'd1;
                    mem_rd_en <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 3'd1;
                    if (skip && cnt == LAT1) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= addr_d;
                        mem_wr_data <= mem_rd_data;
                        in_ready    <= 1'b1;
                        state       <= IDLE;
                    end else if (!skip && cnt == LAT2) begin
                        state <= SUB;
                    end
                end
                SUB: state <= MUL;
                MUL: state <= ADD;
                ADD: begin
                    if (lerp_vld) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= addr_d;
                        mem_wr_data <= lerp_res;
                        in_ready    <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_resize_lerp_engine.sv
// Directed bench for resize_lerp_engine with RD_LAT=1 and RD_LAT=3 instances.
// Expected results are hand-computed fp16 values.
module tb_resize_lerp_engine;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [15:0] mem [256];

    logic        a_valid, a_ready, a_done_in, a_rd_en, a_wr_en, a_done;
    logic [15:0] a_s1, a_s2, a_da, a_fr, a_rd_addr, a_rd_data;
    logic [15:0] a_wr_addr, a_wr_data;
    logic        b_valid, b_ready, b_done_in, b_rd_en, b_wr_en, b_done;
    logic [15:0] b_s1, b_s2, b_da, b_fr, b_rd_addr, b_rd_data;
    logic [15:0] b_wr_addr, b_wr_data;
    logic [15:0] b_p0, b_p1;

    int          wa_c[$], ra_c[$], wb_c[$], rb_c[$];
    logic [15:0] wa_a[$], wa_d[$], ra_a[$];
    logic [15:0] wb_a[$], wb_d[$], rb_a[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    resize_lerp_engine #(.RD_LAT(1)) u_a (
        .clk(clk), .reset_n(reset_n),
        .in_valid(a_valid), .in_ready(a_ready),
        .src_addr1(a_s1), .src_addr2(a_s2),
        .des_addr(a_da), .fraction(a_fr),
        .done_in(a_done_in),
        .mem_rd_en(a_rd_en), .mem_rd_addr(a_rd_addr),
        .mem_rd_data(a_rd_data),
        .mem_wr_en(a_wr_en), .mem_wr_addr(a_wr_addr),
        .mem_wr_data(a_wr_data), .done_out(a_done)
    );

    resize_lerp_engine #(.RD_LAT(3)) u_b (
        .clk(clk), .reset_n(reset_n),
        .in_valid(b_valid), .in_ready(b_ready),
        .src_addr1(b_s1), .src_addr2(b_s2),
        .des_addr(b_da), .fraction(b_fr),
        .done_in(b_done_in),
        .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr),
        .mem_rd_data(b_rd_data),
        .mem_wr_en(b_wr_en), .mem_wr_addr(b_wr_addr),
        .mem_wr_data(b_wr_data), .done_out(b_done)
    );

    // read data is only meaningful in the exact latency slot
    always @(posedge clk) begin
        a_rd_data <= a_rd_en ? mem[a_rd_addr[7:0]] : 16'hDEAD;
        b_p0      <= b_rd_en ? mem[b_rd_addr[7:0]] : 16'hDEAD;
        b_p1      <= b_p0;
        b_rd_data <= b_p1;
    end

    always @(negedge clk) begin
        if (a_wr_en) begin
            wa_c.push_back(cyc);
            wa_a.push_back(a_wr_addr);
            wa_d.push_back(a_wr_data);
        end
        if (a_rd_en) begin
            ra_c.push_back(cyc);
            ra_a.push_back(a_rd_addr);
        end
        if (b_wr_en) begin
            wb_c.push_back(cyc);
            wb_a.push_back(b_wr_addr);
            wb_d.push_back(b_wr_data);
        end
        if (b_rd_en) begin
            rb_c.push_back(cyc);
            rb_a.push_back(b_rd_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic clr();
        wa_c.delete(); wa_a.delete(); wa_d.delete(); ra_c.delete();
        ra_a.delete(); wb_c.delete(); wb_a.delete(); wb_d.delete();
        rb_c.delete(); rb_a.delete();
    endtask

    task automatic chk_wr(input string tag, input int i, input int ec,
                          input logic [15:0] ea, input logic [15:0] ed);
        if (wa_c.size() <= i) begin
            chk({tag, "_missing"}, wa_c.size(), i + 1);
        end else begin
            chk({tag, "_cyc"}, wa_c[i], ec);
            chk({tag, "_addr"}, wa_a[i], ea);
            chk({tag, "_data"}, wa_d[i], ed);
        end
    endtask

    task automatic chk_rd(input string tag, input int i, input int ec,
                          input logic [15:0] ea);
        if (ra_c.size() <= i) begin
            chk({tag, "_missing"}, ra_c.size(), i + 1);
        end else begin
            chk({tag, "_cyc"}, ra_c[i], ec);
            chk({tag, "_addr"}, ra_a[i], ea);
        end
    endtask

    task automatic send(input bit sel, input logic [15:0] s1,
                        input logic [15:0] s2, input logic [15:0] da,
                        input logic [15:0] fr, output int t);
        int n = 0;
        while (!(sel ? b_ready : a_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {31'd0, sel ? b_ready : a_ready}, 1);
        t = cyc;
        if (sel) begin
            b_s1 = s1; b_s2 = s2; b_da = da; b_fr = fr; b_valid = 1'b1;
        end else begin
            a_s1 = s1; a_s2 = s2; a_da = da; a_fr = fr; a_valid = 1'b1;
        end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int acc[3];
        int k, n;
        logic [15:0] js1[3], js2[3], jda[3], jfr[3], jres[3];

        for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
        mem[8'h10] = 16'h3C00; mem[8'h11] = 16'h4000;
        mem[8'h20] = 16'h4200; mem[8'h21] = 16'hC500;
        mem[8'h30] = 16'h3C00; mem[8'h31] = 16'h4400;
        mem[8'h32] = 16'h4000; mem[8'h33] = 16'h4800;
        mem[8'h34] = 16'h4400; mem[8'h35] = 16'h3C00;
        js1 = '{16'h30, 16'h32, 16'h34};
        js2 = '{16'h31, 16'h33, 16'h35};
        jda = '{16'h300, 16'h301, 16'h302};
        jfr = '{16'h3800, 16'h3400, 16'h3A00};
        jres = '{16'h4100, 16'h4300, 16'h3F00};

        a_valid = 0; a_done_in = 0; a_s1 = 0; a_s2 = 0; a_da = 0; a_fr = 0;
        b_valid = 0; b_done_in = 0; b_s1 = 0; b_s2 = 0; b_da = 0; b_fr = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, a_ready}, 0);
        chk("rst_rd_en", {31'd0, a_rd_en}, 0);
        chk("rst_wr_en", {31'd0, a_wr_en}, 0);
        chk("rst_wr_addr", a_wr_addr, 0);
        chk("rst_wr_data", a_wr_data, 0);
        chk("rst_done", {31'd0, a_done}, 0);
        chk("rst_b_done", {31'd0, b_done}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        clr();
        send(0, 16'h10, 16'h11, 16'h100, 16'h3800, t);
        repeat (12) @(negedge clk);
        chk("s1_wr_n", wa_c.size(), 1);
        chk_wr("s1_wr", 0, t + 7, 16'h100, 16'h3E00);
        chk("s1_rd_n", ra_c.size(), 2);
        chk_rd("s1_rd0", 0, t + 1, 16'h10);
        chk_rd("s1_rd1", 1, t + 2, 16'h11);

        clr();
        send(0, 16'h20, 16'hFFF0, 16'h200, 16'h0000, t);
        repeat (8) @(negedge clk);
        chk("s2_wr_n", wa_c.size(), 1);
        chk_wr("s2_wr", 0, t + 3, 16'h200, 16'h4200);
        chk("s2_rd_n", ra_c.size(), 1);
        chk_rd("s2_rd0", 0, t + 1, 16'h20);

        clr();
        send(0, 16'h21, 16'hFFF1, 16'h201, 16'h8000, t);
        repeat (8) @(negedge clk);
        chk("s2n_rd_n", ra_c.size(), 1);
        chk_wr("s2n_wr", 0, t + 3, 16'h201, 16'hC500);

        clr();
        a_valid = 1'b1;
        k = 0;
        n = 0;
        while (k < 3 && n < 60) begin
            if (a_ready) begin
                a_s1 = js1[k]; a_s2 = js2[k]; a_da = jda[k]; a_fr = jfr[k];
                acc[k] = cyc;
                k++;
            end
            @(negedge clk);
            n++;
        end
        a_valid = 1'b0;
        chk("s3_accepts", k, 3);
        repeat (12) @(negedge clk);
        chk("s3_gap1", acc[1] - acc[0], 7);
        chk("s3_gap2", acc[2] - acc[1], 7);
        chk("s3_wr_n", wa_c.size(), 3);
        chk("s3_rd_n", ra_c.size(), 6);
        for (int i = 0; i < 3; i++)
            chk_wr($sformatf("s3_wr%0d", i), i, acc[i] + 7, jda[i], jres[i]);

        clr();
        send(1, 16'h10, 16'h11, 16'h110, 16'h3800, t);
        repeat (14) @(negedge clk);
        chk("s4_wr_n", wb_c.size(), 1);
        if (wb_c.size() > 0) begin
            chk("s4_wr_cyc", wb_c[0], t + 9);
            chk("s4_wr_addr", wb_a[0], 16'h110);
            chk("s4_wr_data", wb_d[0], 16'h3E00);
        end
        chk("s4_rd_n", rb_c.size(), 2);
        chk("s4_a_idle", wa_c.size(), 0);

        clr();
        send(0, 16'h30, 16'h31, 16'h3FF, 16'h3800, t);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("s5_rd_addr", a_rd_addr, 0);
        chk("s5_wr_addr", a_wr_addr, 0);
        chk("s5_wr_data", a_wr_data, 0);
        chk("s5_ready", {31'd0, a_ready}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("s5_no_wr", wa_c.size(), 0);
        send(0, 16'h32, 16'h33, 16'h301, 16'h3400, t);
        repeat (10) @(negedge clk);
        chk_wr("s5_next", 0, t + 7, 16'h301, 16'h4300);

        clr();
        send(0, 16'h10, 16'h11, 16'h100, 16'h3800, t);
        repeat (4) @(negedge clk);
        a_done_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("s6_wr_en", {31'd0, a_wr_en}, 1);
        chk("s6_done_pre", {31'd0, a_done}, 0);
        @(negedge clk);
        chk("s6_done", {31'd0, a_done}, 1);
        chk("s6_ready", {31'd0, a_ready}, 0);
        a_done_in = 1'b0;
        a_s1 = 16'h20; a_s2 = 16'h21; a_da = 16'h222; a_fr = 16'h3800;
        a_valid = 1'b1;
        repeat (6) @(negedge clk);
        a_valid = 1'b0;
        chk("s6_done_hold", {31'd0, a_done}, 1);
        chk("s6_ready_hold", {31'd0, a_ready}, 0);
        chk("s6_rd_n", ra_c.size(), 2);
        chk("s6_wr_n", wa_c.size(), 1);
        chk_wr("s6_wr", 0, t + 7, 16'h100, 16'h3E00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
